// File: rtl/hazard_unit_sb.sv
// Pipeline hazard unit: load-use scoreboard, MDU busy tracking, jump/branch flush priority.
// Optional stall-cycle performance counter built when HAZARD_PERF_CNT_EN is defined.
module hazard_unit_sb #(
    parameter int REG_ADDR_W  = 5,
    parameter int LOAD_STAGES = 1,
    parameter int MDU_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] ifid_rs_i,
    input  logic [REG_ADDR_W-1:0] ifid_rt_i,
    input  logic                  ifid_uses_rt_i,
    input  logic                  ifid_mdu_read_i,
    input  logic                  idex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] idex_rt_i,
    input  logic                  mdu_start_i,
    input  logic                  jmp_ctl_i,
    input  logic                  jr_i,
    input  logic                  branch_taken_i,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  ctl_flush_o,
    output logic                  ifid_flush_o,
    output logic                  idex_flush_o,
    output logic [31:0]           stall_cycles_o
);

    localparam int MDU_W = (MDU_CYCLES > 1) ? $clog2(MDU_CYCLES) : 1;
    localparam logic [MDU_W-1:0] MDU_RELOAD = MDU_W'(MDU_CYCLES - 1);

    logic                  w_e0_valid;
    logic [REG_ADDR_W-1:0] w_e0_tag;
    logic                  w_e0_hz;
    logic                  w_sb_hz;
    logic                  w_load_hz;
    logic                  w_mdu_busy;
    logic                  w_mdu_hz;
    logic                  w_stall;
    logic [MDU_W-1:0]      r_mdu_cnt;

    // Entry 0 is the load currently in EX; register 0 is never a valid tag.
    assign w_e0_valid = idex_mem_read_i && (idex_rt_i != '0);
    assign w_e0_tag   = idex_rt_i;
    assign w_e0_hz    = w_e0_valid &&
                        ((w_e0_tag == ifid_rs_i) || (ifid_uses_rt_i && (w_e0_tag == ifid_rt_i)));

    generate
        if (LOAD_STAGES > 1) begin : g_sb
            logic [LOAD_STAGES-1:1] r_sb_valid;
            logic [REG_ADDR_W-1:0]  r_sb_tag [1:LOAD_STAGES-1];

            // Loads age through the scoreboard whether or not the pipeline is stalled.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sb_valid <= '0;
                    for (int k = 1; k < LOAD_STAGES; k++) r_sb_tag[k] <= '0;
                end else begin
                    r_sb_valid[1] <= w_e0_valid;
                    r_sb_tag[1]   <= w_e0_tag;
                    for (int k = 2; k < LOAD_STAGES; k++) begin
                        r_sb_valid[k] <= r_sb_valid[k-1];
                        r_sb_tag[k]   <= r_sb_tag[k-1];
                    end
                end
            end

            always_comb begin
                w_sb_hz = 1'b0;
                for (int k = 1; k < LOAD_STAGES; k++) begin
                    if (r_sb_valid[k] &&
                        ((r_sb_tag[k] == ifid_rs_i) ||
                         (ifid_uses_rt_i && (r_sb_tag[k] == ifid_rt_i))))
                        w_sb_hz = 1'b1;
                end
            end
        end else begin : g_no_sb
            assign w_sb_hz = 1'b0;
        end
    endgenerate

    assign w_load_hz = w_e0_hz || w_sb_hz;

    // A new mult/div reloads the counter even while a previous one is still busy.
    always_ff @(posedge clk) begin
        if (reset)
            r_mdu_cnt <= '0;
        else if (mdu_start_i)
            r_mdu_cnt <= MDU_RELOAD;
        else if (r_mdu_cnt != '0)
            r_mdu_cnt <= r_mdu_cnt - MDU_W'(1);
    end

    assign w_mdu_busy = mdu_start_i || (r_mdu_cnt != '0);
    assign w_mdu_hz   = ifid_mdu_read_i && w_mdu_busy;
    assign w_stall    = w_load_hz || w_mdu_hz;

    // Taken branch beats stall (ID is wrong-path); stall beats jumps (jr needs its rs).
    always_comb begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ctl_flush_o  = 1'b1;
        ifid_flush_o = 1'b1;
        idex_flush_o = 1'b1;
        if (!reset) begin
            if (branch_taken_i) begin
                ifid_flush_o = 1'b0;
                idex_flush_o = 1'b0;
            end else if (w_stall) begin
                pc_write_o   = 1'b0;
                ifid_write_o = 1'b0;
                ctl_flush_o  = 1'b0;
            end else if (jmp_ctl_i || jr_i) begin
                ifid_flush_o = 1'b0;
                idex_flush_o = 1'b0;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_stall_cnt <= '0;
        else if (!pc_write_o && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cycles_o = reset ? 32'd0 : r_stall_cnt;
`else
    assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Bench for hazard_unit_sb: two instances (LOAD_STAGES=1 and 3) share stimulus and are
// checked against a cycle-history reference model, a vector table and hand sequences.
module tb_hazard_unit_sb;

    localparam int MDU = 4;
    localparam logic [4:0] N = 5'b11111;
    localparam logic [4:0] S = 5'b00011;
    localparam logic [4:0] F = 5'b11100;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] ifid_rs, ifid_rt, idex_rt;
    logic       uses_rt, mdu_read, mem_read, mdu_start, jmp, jr, br;

    logic pc1, ifw1, ctl1, iff1, idf1;
    logic pc3, ifw3, ctl3, iff3, idf3;
    logic [31:0] sc1, sc3;
    logic [4:0] o1, o3;
    assign o1 = {pc1, ifw1, ctl1, iff1, idf1};
    assign o3 = {pc3, ifw3, ctl3, iff3, idf3};

    hazard_unit_sb #(.REG_ADDR_W(5), .LOAD_STAGES(1), .MDU_CYCLES(MDU)) dut1 (
        .clk(clk), .reset(reset),
        .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt), .ifid_uses_rt_i(uses_rt),
        .ifid_mdu_read_i(mdu_read), .idex_mem_read_i(mem_read), .idex_rt_i(idex_rt),
        .mdu_start_i(mdu_start), .jmp_ctl_i(jmp), .jr_i(jr), .branch_taken_i(br),
        .pc_write_o(pc1), .ifid_write_o(ifw1), .ctl_flush_o(ctl1),
        .ifid_flush_o(iff1), .idex_flush_o(idf1), .stall_cycles_o(sc1)
    );

    hazard_unit_sb #(.REG_ADDR_W(5), .LOAD_STAGES(3), .MDU_CYCLES(MDU)) dut3 (
        .clk(clk), .reset(reset),
        .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt), .ifid_uses_rt_i(uses_rt),
        .ifid_mdu_read_i(mdu_read), .idex_mem_read_i(mem_read), .idex_rt_i(idex_rt),
        .mdu_start_i(mdu_start), .jmp_ctl_i(jmp), .jr_i(jr), .branch_taken_i(br),
        .pc_write_o(pc3), .ifid_write_o(ifw3), .ctl_flush_o(ctl3),
        .ifid_flush_o(iff3), .idex_flush_o(idf3), .stall_cycles_o(sc3)
    );

    int checks = 0;
    int failures = 0;

    // Reference state: load destinations seen k cycles ago, cycle index of last mult/div
    // start, and stall-cycle totals since the last reset.
    int hist [1:3];
    int cyc = 0;
    int last_start = -1000;
    int cnt1 = 0;
    int cnt3 = 0;

    function automatic bit tag_hit(int tag);
        return (tag != 0) && ((tag == int'(ifid_rs)) || (uses_rt && (tag == int'(ifid_rt))));
    endfunction

    function automatic bit load_hz(int ls);
        bit h = 1'b0;
        if (mem_read && tag_hit(int'(idex_rt))) h = 1'b1;
        for (int k = 1; k < ls; k++) if (tag_hit(hist[k])) h = 1'b1;
        return h;
    endfunction

    function automatic logic [4:0] model_out(int ls);
        bit busy, st;
        if (reset) return N;
        busy = mdu_start || ((cyc - last_start) < MDU);
        st = load_hz(ls) || (mdu_read && busy);
        if (br) return F;
        if (st) return S;
        if (jmp || jr) return F;
        return N;
    endfunction

    task automatic check5(input string nm, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got={pc,ifw,ctl,iff,idf}=%b expected=%b", nm, cyc, act, exp);
        end
    endtask

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    // e1/e3/ep < 0 means "no explicit expectation"; the model is always checked.
    task automatic step(input string nm, input int e1, input int e3, input int ep = -1);
        logic [4:0] m1, m3;
        @(negedge clk);
        m1 = model_out(1);
        m3 = model_out(3);
        check5({nm, "/ls1"}, o1, m1);
        check5({nm, "/ls3"}, o3, m3);
        if (e1 >= 0) check5({nm, "/ls1_exp"}, o1, 5'(e1));
        if (e3 >= 0) check5({nm, "/ls3_exp"}, o3, 5'(e3));
        check32({nm, "/perf1"}, sc1, (PERF && !reset) ? 32'(cnt1) : 32'd0);
        check32({nm, "/perf3"}, sc3, (PERF && !reset) ? 32'(cnt3) : 32'd0);
        if (ep >= 0) check32({nm, "/perf_exp"}, sc1, 32'(ep));
        @(posedge clk);
        if (reset) begin
            foreach (hist[k]) hist[k] = 0;
            last_start = -1000;
            cnt1 = 0;
            cnt3 = 0;
        end else begin
            hist[3] = hist[2];
            hist[2] = hist[1];
            hist[1] = (mem_read && idex_rt != 5'd0) ? int'(idex_rt) : 0;
            if (mdu_start) last_start = cyc;
            if (!m1[4]) cnt1++;
            if (!m3[4]) cnt3++;
        end
        cyc++;
        #1;
    endtask

    task automatic clear_in();
        reset = 1'b0; ifid_rs = '0; ifid_rt = '0; idex_rt = '0;
        uses_rt = 1'b0; mdu_read = 1'b0; mem_read = 1'b0; mdu_start = 1'b0;
        jmp = 1'b0; jr = 1'b0; br = 1'b0;
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1'b1;
        step("reset", N, N, 0);
        reset = 1'b0;
    endtask

    typedef struct {
        logic       mem_read;
        logic [4:0] idex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       mdu_read;
        logic       jmp;
        logic       jr;
        logic       br;
        logic [4:0] exp1;
    } vec_t;

    vec_t tbl [12];

    initial begin
        foreach (hist[k]) hist[k] = 0;
        clear_in();
        reset = 1'b1;

        //            mem rt   rs   rt   urt mdr jmp jr  br  exp(LS=1)
        tbl[0]  = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S};
        tbl[1]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, N};
        tbl[2]  = '{1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, N};
        tbl[3]  = '{1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S};
        tbl[4]  = '{1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, N};
        tbl[5]  = '{1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, F};
        tbl[6]  = '{1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, F};
        tbl[7]  = '{1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S};
        tbl[8]  = '{1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, F};
        tbl[9]  = '{1'b0, 5'd0, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, F};
        tbl[10] = '{1'b0, 5'd0, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, N};
        tbl[11] = '{1'b1, 5'd6, 5'd6, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, F};

        do_reset();
        foreach (tbl[i]) begin
            mem_read = tbl[i].mem_read; idex_rt = tbl[i].idex_rt;
            ifid_rs = tbl[i].rs; ifid_rt = tbl[i].rt; uses_rt = tbl[i].uses_rt;
            mdu_read = tbl[i].mdu_read; jmp = tbl[i].jmp; jr = tbl[i].jr; br = tbl[i].br;
            step($sformatf("tbl%0d", i), int'(tbl[i].exp1), -1);
        end

        // Load rt=5 followed by bubbles, ID keeps rs=5: LS=1 stalls 1 cycle, LS=3 stalls 3.
        do_reset();
        ifid_rs = 5'd5; mem_read = 1'b1; idex_rt = 5'd5;
        step("ls_c0", S, S);
        mem_read = 1'b0; idex_rt = 5'd0;
        step("ls_c1", N, S);
        step("ls_c2", N, S);
        step("ls_c3", N, N);
        step("ls_c4", N, N);

        // Reset wins over a same-cycle mult/div start.
        clear_in();
        reset = 1'b1; mdu_start = 1'b1;
        step("rst_mdu", N, N);
        reset = 1'b0; mdu_start = 1'b0; mdu_read = 1'b1;
        step("rst_mdu_after", N, N);

        // mfhi behind a 4-cycle multiply.
        do_reset();
        mdu_start = 1'b1;
        step("mdu_c0", N, N);
        mdu_start = 1'b0; mdu_read = 1'b1;
        step("mdu_c1", S, S);
        step("mdu_c2", S, S);
        step("mdu_c3", S, S);
        step("mdu_c4", N, N);

        // Reload at cycle 2 extends the stall through cycle 5.
        do_reset();
        mdu_start = 1'b1;
        step("rld_c0", N, N);
        mdu_start = 1'b0; mdu_read = 1'b1;
        step("rld_c1", S, S);
        mdu_start = 1'b1;
        step("rld_c2", S, S);
        mdu_start = 1'b0;
        step("rld_c3", S, S);
        step("rld_c4", S, S);
        step("rld_c5", S, S);
        step("rld_c6", N, N);

        // jr deferred by an MDU stall, flushes once the stall clears.
        do_reset();
        mdu_start = 1'b1;
        step("jr_c0", N, N);
        mdu_start = 1'b0; mdu_read = 1'b1; jr = 1'b1;
        step("jr_c1", S, S);
        step("jr_c2", S, S);
        step("jr_c3", S, S);
        step("jr_c4", F, F);

        // Seven stall cycles, then a reset in the middle of a later stall.
        do_reset();
        mem_read = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
        for (int i = 0; i < 7; i++) step("perf_stall", S, S);
        clear_in();
        step("perf7", N, N, PERF ? 7 : 0);
        mem_read = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
        step("perf_stall8", S, S);
        step("perf_stall9", S, S, PERF ? 8 : 0);
        reset = 1'b1;
        step("perf_rst", N, N, 0);
        reset = 1'b0;
        step("perf_post_rst", S, S, 0);
        step("perf_post_rst2", S, S, PERF ? 1 : 0);

        // Randomised traffic over a small register range to provoke matches.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 39) == 0);
            ifid_rs   = 5'($urandom_range(0, 3));
            ifid_rt   = 5'($urandom_range(0, 3));
            idex_rt   = 5'($urandom_range(0, 3));
            uses_rt   = 1'($urandom_range(0, 1));
            mem_read  = ($urandom_range(0, 2) == 0);
            mdu_read  = ($urandom_range(0, 2) == 0);
            mdu_start = ($urandom_range(0, 9) == 0);
            jmp       = ($urandom_range(0, 7) == 0);
            jr        = ($urandom_range(0, 7) == 0);
            br        = ($urandom_range(0, 7) == 0);
            step("rand", -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
